// File: rtl/wb_arbiter_pkg.sv
// Shared types and defaults for the writeback arbiter.
//   wb_src_e  : which source drives the register write port in a given cycle
//   wb_req_t  : one register write (destination + data) at default widths
//   defaults  : architectural register count, data width, LSU holding depth
package wb_arbiter_pkg;

  localparam int NUM_REGS             = 32;
  localparam int XLEN_DEFAULT         = 32;
  localparam int WB_LSU_DEPTH_DEFAULT = 2;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_ALU,
    WB_SRC_LSU_Q,
    WB_SRC_LSU_BYP
  } wb_src_e;

  typedef struct packed {
    logic [$clog2(NUM_REGS)-1:0] waddr;
    logic [XLEN_DEFAULT-1:0]     wdata;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous holding FIFO for accepted load writebacks.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   enqueue at tail (caller never pushes when full)
//   pop, head         dequeue head (caller never pops when empty)
//   full, empty       occupancy flags
//   count             number of valid entries
//   entry_vld         per-slot valid bit, used for pending-mask generation
//   entries           raw slot contents, paired with entry_vld
// DEPTH need not be a power of two; pointers wrap explicitly.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter type req_t = wb_req_t,
  parameter int  DEPTH = WB_LSU_DEPTH_DEFAULT,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  req_t             push_data,
  input  logic             pop,
  output req_t             head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [DEPTH-1:0] entry_vld,
  output req_t             entries [DEPTH]
);

  req_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] vld_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Clear before set: a same-cycle pop and push only share a slot when
  // the FIFO is full, which the caller prevents.
  always_comb begin
    vld_nxt = entry_vld;
    if (pop)  vld_nxt[rd_ptr] = 1'b0;
    if (push) vld_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      entry_vld <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      entry_vld <= vld_nxt;
    end
  end

  // Payload storage needs no reset; entry_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head    = mem[rd_ptr];
  assign entries = mem;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter feeding the single register-file write port.
// Merges the non-stallable ALU result with the LSU load-response channel
// (valid/ready). ALU has strict priority; accepted loads wait in a small
// FIFO and retire in acceptance order. A load that arrives while nothing
// else wants the port bypasses the FIFO.
// Ports:
//   i_clk, i_rst_n                         clock, async active-low reset
//   i_alu_we/i_alu_waddr/i_alu_wdata       ALU result
//   i_lsu_valid/o_lsu_ready                load response handshake
//   i_lsu_waddr/i_lsu_wdata                load response payload
//   o_we/o_waddr/o_wdata                   register write port
//   o_pending_mask                         loads accepted but not yet written
// Build option: define WB_REG_OUT_EN to register the write port outputs
// (1-cycle latency); otherwise the outputs are combinational.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int  N_REGS    = NUM_REGS,
  parameter int  XLEN      = XLEN_DEFAULT,
  parameter int  LSU_DEPTH = WB_LSU_DEPTH_DEFAULT,
  localparam int AW        = $clog2(N_REGS),
  localparam int CNT_W     = $clog2(LSU_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_alu_we,
  input  logic [AW-1:0]     i_alu_waddr,
  input  logic [XLEN-1:0]   i_alu_wdata,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [AW-1:0]     i_lsu_waddr,
  input  logic [XLEN-1:0]   i_lsu_wdata,
  output logic              o_we,
  output logic [AW-1:0]     o_waddr,
  output logic [XLEN-1:0]   o_wdata,
  output logic [N_REGS-1:0] o_pending_mask
);

  typedef struct packed {
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
  } req_t;

  logic             active_q;
  logic             alu_hit;
  logic             lsu_live;
  wb_src_e          sel_src;
  req_t             sel_req;
  logic             fifo_push;
  logic             fifo_pop;
  req_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic [LSU_DEPTH-1:0] fifo_vld;
  req_t             fifo_entries [LSU_DEPTH];

  // Goes high on the first clock edge after reset release; holds ready low
  // and suppresses writes while in reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) active_q <= 1'b0;
    else          active_q <= 1'b1;
  end

  assign o_lsu_ready = active_q && (int'(fifo_count) < LSU_DEPTH);

  always_comb begin
    alu_hit  = i_alu_we && (i_alu_waddr != '0);
    // x0 loads complete the handshake but are otherwise dropped.
    lsu_live = i_lsu_valid && o_lsu_ready && (i_lsu_waddr != '0);
    sel_src  = WB_SRC_NONE;
    if (active_q) begin
      if (alu_hit)          sel_src = WB_SRC_ALU;
      else if (!fifo_empty) sel_src = WB_SRC_LSU_Q;
      else if (lsu_live)    sel_src = WB_SRC_LSU_BYP;
    end
    case (sel_src)
      WB_SRC_ALU:     sel_req = '{waddr: i_alu_waddr, wdata: i_alu_wdata};
      WB_SRC_LSU_Q:   sel_req = fifo_head;
      WB_SRC_LSU_BYP: sel_req = '{waddr: i_lsu_waddr, wdata: i_lsu_wdata};
      default:        sel_req = '0;
    endcase
    fifo_pop  = (sel_src == WB_SRC_LSU_Q);
    fifo_push = lsu_live && (sel_src != WB_SRC_LSU_BYP) && !fifo_full;
  end

  wb_fifo #(
    .req_t (req_t),
    .DEPTH (LSU_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .push      (fifo_push),
    .push_data ('{waddr: i_lsu_waddr, wdata: i_lsu_wdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .entry_vld (fifo_vld),
    .entries   (fifo_entries)
  );

`ifdef WB_REG_OUT_EN
  logic out_lsu_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_we      <= 1'b0;
      o_waddr   <= '0;
      o_wdata   <= '0;
      out_lsu_q <= 1'b0;
    end else begin
      o_we      <= (sel_src != WB_SRC_NONE);
      o_waddr   <= sel_req.waddr;
      o_wdata   <= sel_req.wdata;
      out_lsu_q <= (sel_src == WB_SRC_LSU_Q) || (sel_src == WB_SRC_LSU_BYP);
    end
  end
`else
  assign o_we    = (sel_src != WB_SRC_NONE);
  assign o_waddr = sel_req.waddr;
  assign o_wdata = sel_req.wdata;
`endif

  always_comb begin
    o_pending_mask = '0;
    for (int i = 0; i < LSU_DEPTH; i++) begin
      if (fifo_vld[i]) o_pending_mask[fifo_entries[i].waddr] = 1'b1;
    end
`ifdef WB_REG_OUT_EN
    // A load sitting in the output register has not reached the file yet.
    if (o_we && out_lsu_q) o_pending_mask[o_waddr] = 1'b1;
`endif
  end

endmodule
